// File: rtl/fft_fsm_pkg.sv
// Shared FFT control types: FSM state encoding, default transform size and
// the bit-reversal helper used for sample-load addressing.
package fft_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    ACTIVE_WRITE   = 3'd1,
    READ_1         = 3'd2,
    READ_2         = 3'd3,
    COMPUTE        = 3'd4,
    WRITE_RESULT_1 = 3'd5,
    WRITE_RESULT_2 = 3'd6,
    DONE           = 3'd7
  } state_fsm;

  localparam int FFT_N     = 16;
  localparam int FFT_LOG2N = 4;

  // Reverses the low w bits of v; bits at or above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        r = r | (((v >> i) & 32'd1) << (w - 1 - i));
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly_cnt.sv
// Stage/butterfly counter for the radix-2 DIT schedule. Advances once per
// retired butterfly and wraps to stage 0, butterfly 0 after the last one.
module fft_bfly_cnt
  import fft_fsm_pkg::*;
#(
  parameter  int N_POINTS = FFT_N,
  localparam int ADDR_W   = $clog2(N_POINTS),
  localparam int SW       = $clog2(ADDR_W),
  localparam int BW       = ADDR_W - 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [SW-1:0] stage_o,
  output logic [BW-1:0] bfly_o,
  output logic          last_o
);

  localparam logic [BW-1:0] BFLY_MAX  = BW'(N_POINTS / 2 - 1);
  localparam logic [SW-1:0] STAGE_MAX = SW'(ADDR_W - 1);

  logic [SW-1:0] r_stage;
  logic [BW-1:0] r_bfly;
  logic          w_bfly_end;

  assign w_bfly_end = (r_bfly == BFLY_MAX);
  assign last_o     = w_bfly_end && (r_stage == STAGE_MAX);
  assign stage_o    = r_stage;
  assign bfly_o     = r_bfly;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stage <= '0;
      r_bfly  <= '0;
    end else if (clr_i) begin
      r_stage <= '0;
      r_bfly  <= '0;
    end else if (adv_i) begin
      if (last_o) begin
        r_stage <= '0;
        r_bfly  <= '0;
      end else if (w_bfly_end) begin
        r_stage <= r_stage + SW'(1);
        r_bfly  <= '0;
      end else begin
        r_bfly  <= r_bfly + BW'(1);
      end
    end
  end

endmodule

// File: rtl/fft_addr_gen.sv
// FFT address/sequencing generator: sample-load and butterfly addressing,
// twiddle index, and the completion flags consumed by the control FSM.
module fft_addr_gen
  import fft_fsm_pkg::*;
#(
  parameter  int N_POINTS = FFT_N,
  parameter  int RD_LAT   = 1,
  localparam int ADDR_W   = $clog2(N_POINTS),
  localparam int SW       = $clog2(ADDR_W),
  localparam int TW       = ADDR_W - 1,
  localparam int RW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  state_fsm          state_i,
  input  logic              en_cnt_samples_i,
  input  logic              wr_mem_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              mem_we_o,
  output logic [TW-1:0]     tw_idx_o,
  output logic [SW-1:0]     stage_o,
  output logic              end_samples_o,
  output logic              end_read_1_o,
  output logic              end_read_2_o,
  output logic              end_write_1_o,
  output logic              end_algo_o
);

  logic [ADDR_W-1:0] r_smp_cnt;
  logic [RW-1:0]     r_rd_wait;
  logic              r_wr_sub;

  logic [SW-1:0]     w_stage;
  logic [ADDR_W-2:0] w_bfly;
  logic              w_last;
  logic              w_clr;
  logic              w_in_read;
  logic              w_rd_done;
  logic              w_end_algo;
  logic [ADDR_W-1:0] w_bfly_ext;
  logic [ADDR_W-1:0] w_half;
  logic [ADDR_W-1:0] w_pos;
  logic [ADDR_W-1:0] w_grp;
  logic [ADDR_W-1:0] w_addr_a;
  logic [ADDR_W-1:0] w_addr_b;
  logic [SW-1:0]     w_tw_sh;
  logic [TW-1:0]     w_tw;
  logic [ADDR_W-1:0] w_wr_rev;

  fft_bfly_cnt #(.N_POINTS(N_POINTS)) u_bfly_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (w_clr),
    .adv_i   (state_i == WRITE_RESULT_2),
    .stage_o (w_stage),
    .bfly_o  (w_bfly),
    .last_o  (w_last)
  );

  // IDLE, DONE and any unknown encoding hold the generator in its cleared state.
  always_comb begin
    w_clr = 1'b1;
    case (state_i)
      ACTIVE_WRITE, READ_1, READ_2, COMPUTE,
      WRITE_RESULT_1, WRITE_RESULT_2: w_clr = 1'b0;
      default:                        w_clr = 1'b1;
    endcase
  end

  assign w_in_read  = (state_i == READ_1) || (state_i == READ_2);
  assign w_rd_done  = w_in_read && (r_rd_wait == RW'(RD_LAT - 1));
  assign w_end_algo = (state_i == WRITE_RESULT_2) && w_last;

  // grp*2*half + pos is formed as (grp << stage) << 1 so the shift never overflows stage.
  assign w_bfly_ext = {1'b0, w_bfly};
  assign w_half     = ADDR_W'(1) << w_stage;
  assign w_pos      = w_bfly_ext & (w_half - ADDR_W'(1));
  assign w_grp      = w_bfly_ext >> w_stage;
  assign w_addr_a   = ((w_grp << w_stage) << 1) | w_pos;
  assign w_addr_b   = w_addr_a + w_half;
  assign w_tw_sh    = SW'(ADDR_W - 1) - w_stage;
  assign w_tw       = TW'(w_pos) << w_tw_sh;
  assign w_wr_rev   = ADDR_W'(bitrev(32'(r_smp_cnt), ADDR_W));
  assign stage_o    = w_stage;

  // Load counter and read/write sub-step counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_smp_cnt <= '0;
      r_rd_wait <= '0;
      r_wr_sub  <= 1'b0;
    end else if (w_clr || w_end_algo) begin
      r_smp_cnt <= '0;
      r_rd_wait <= '0;
      r_wr_sub  <= 1'b0;
    end else begin
      if ((state_i == ACTIVE_WRITE) && en_cnt_samples_i) begin
        r_smp_cnt <= r_smp_cnt + ADDR_W'(1);
      end
      if (w_in_read) begin
        r_rd_wait <= w_rd_done ? RW'(0) : (r_rd_wait + RW'(1));
      end
      if ((state_i == WRITE_RESULT_1) && wr_mem_i) begin
        r_wr_sub <= ~r_wr_sub;
      end
    end
  end

  // Per-state output muxing; anything not listed stays at zero.
  always_comb begin
    rd_addr_o     = '0;
    wr_addr_o     = '0;
    mem_we_o      = 1'b0;
    tw_idx_o      = '0;
    end_samples_o = 1'b0;
    end_read_1_o  = 1'b0;
    end_read_2_o  = 1'b0;
    end_write_1_o = 1'b0;
    end_algo_o    = 1'b0;
    case (state_i)
      ACTIVE_WRITE: begin
        wr_addr_o     = w_wr_rev;
        mem_we_o      = wr_mem_i;
        end_samples_o = en_cnt_samples_i && (r_smp_cnt == ADDR_W'(N_POINTS - 1));
      end
      READ_1: begin
        rd_addr_o    = w_addr_a;
        tw_idx_o     = w_tw;
        end_read_1_o = w_rd_done;
      end
      READ_2: begin
        rd_addr_o    = w_addr_b;
        tw_idx_o     = w_tw;
        end_read_2_o = w_rd_done;
      end
      COMPUTE: begin
        tw_idx_o = w_tw;
      end
      WRITE_RESULT_1: begin
        wr_addr_o     = r_wr_sub ? w_addr_b : w_addr_a;
        mem_we_o      = wr_mem_i;
        tw_idx_o      = w_tw;
        end_write_1_o = wr_mem_i && r_wr_sub;
      end
      WRITE_RESULT_2: begin
        tw_idx_o   = w_tw;
        end_algo_o = w_end_algo;
      end
      default: begin
        rd_addr_o = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fft_addr_gen.sv
// Scoreboard bench for fft_addr_gen (N=16): a driver queues expected outputs
// per cycle and a negedge monitor pops and compares them.
module tb_fft_addr_gen;
  import fft_fsm_pkg::*;

  typedef struct {
    string       name;
    logic [18:0] v;
    logic        chk_tw;
    logic        chk3;
    logic [1:0]  f3;
  } exp_t;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  state_fsm st  = IDLE;
  logic     en  = 1'b0;
  logic     wr  = 1'b0;
  logic     stim_v = 1'b0;

  logic [3:0] rd_addr, wr_addr, rd_addr3, wr_addr3;
  logic       we, we3;
  logic [2:0] tw, tw3;
  logic [1:0] stage, stage3;
  logic       e_smp, e_r1, e_r2, e_w1, e_alg;
  logic       e_smp3, e_r13, e_r23, e_w13, e_alg3;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t cur;
  logic [18:0] act;
  int   BR [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  always #5 clk = ~clk;

  fft_addr_gen #(.N_POINTS(16), .RD_LAT(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .state_i(st), .en_cnt_samples_i(en), .wr_mem_i(wr),
    .rd_addr_o(rd_addr), .wr_addr_o(wr_addr), .mem_we_o(we), .tw_idx_o(tw),
    .stage_o(stage), .end_samples_o(e_smp), .end_read_1_o(e_r1),
    .end_read_2_o(e_r2), .end_write_1_o(e_w1), .end_algo_o(e_alg)
  );

  fft_addr_gen #(.N_POINTS(16), .RD_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .state_i(st), .en_cnt_samples_i(en), .wr_mem_i(wr),
    .rd_addr_o(rd_addr3), .wr_addr_o(wr_addr3), .mem_we_o(we3), .tw_idx_o(tw3),
    .stage_o(stage3), .end_samples_o(e_smp3), .end_read_1_o(e_r13),
    .end_read_2_o(e_r23), .end_write_1_o(e_w13), .end_algo_o(e_alg3)
  );

  // flags = {end_samples, end_read_1, end_read_2, end_write_1, end_algo}
  function automatic exp_t mk(input string n, input int rda, input int wra, input bit mwe,
                              input int twi, input bit ctw, input int stg,
                              input logic [4:0] fl, input bit c3, input logic [1:0] f3);
    exp_t e;
    e.name   = n;
    e.v      = {4'(rda), 4'(wra), mwe, (ctw ? 3'(twi) : 3'd0), 2'(stg), fl};
    e.chk_tw = ctw;
    e.chk3   = c3;
    e.f3     = f3;
    return e;
  endfunction

  task automatic step(input state_fsm s, input logic e_en, input logic e_wr, input exp_t x);
    @(posedge clk);
    #1;
    st     = s;
    en     = e_en;
    wr     = e_wr;
    stim_v = 1'b1;
    q.push_back(x);
  endtask

  task automatic run_bfly(input int max_b);
    int n, h, a, b, t;
    logic lst;
    n = 0;
    for (int s = 0; s < 4; s++) begin
      h = 1 << s;
      for (int g = 0; g < (8 >> s); g++) begin
        for (int p = 0; p < h; p++) begin
          if (n == max_b) return;
          a   = g * 2 * h + p;
          b   = a + h;
          t   = p * (8 >> s);
          lst = (n == 31);
          step(READ_1, 1'b0, 1'b0, mk($sformatf("bf%0d_r1", n), a, 0, 0, t, 1, s, 5'b01000, 0, 2'b00));
          step(READ_2, 1'b0, 1'b0, mk($sformatf("bf%0d_r2", n), b, 0, 0, t, 1, s, 5'b00100, 0, 2'b00));
          step(COMPUTE, 1'b0, 1'b0, mk($sformatf("bf%0d_cmp", n), 0, 0, 0, 0, 0, s, 5'b00000, 0, 2'b00));
          step(WRITE_RESULT_1, 1'b0, 1'b1, mk($sformatf("bf%0d_w1a", n), 0, a, 1, 0, 0, s, 5'b00000, 0, 2'b00));
          step(WRITE_RESULT_1, 1'b0, 1'b1, mk($sformatf("bf%0d_w1b", n), 0, b, 1, 0, 0, s, 5'b00010, 0, 2'b00));
          step(WRITE_RESULT_2, 1'b0, 1'b0, mk($sformatf("bf%0d_w2", n), 0, 0, 0, 0, 0, s,
                                               lst ? 5'b00001 : 5'b00000, 0, 2'b00));
          n++;
        end
      end
    end
  endtask

  // Monitor: one expected record per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (stim_v) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL underflow: output cycle with no expected record");
      end else begin
        cur = q.pop_front();
        act = {rd_addr, wr_addr, we, (cur.chk_tw ? tw : 3'd0), stage, e_smp, e_r1, e_r2, e_w1, e_alg};
        checks++;
        if (act !== cur.v) begin
          errors++;
          $display("FAIL %s got rd=%0d wr=%0d we=%b tw=%0d st=%0d fl=%b want rd=%0d wr=%0d we=%b tw=%0d st=%0d fl=%b",
                   cur.name, act[18:15], act[14:11], act[10], act[9:7], act[6:5], act[4:0],
                   cur.v[18:15], cur.v[14:11], cur.v[10], cur.v[9:7], cur.v[6:5], cur.v[4:0]);
        end
        if (cur.chk3) begin
          checks++;
          if ({e_r13, e_r23} !== cur.f3) begin
            errors++;
            $display("FAIL %s_lat3 got r1r2=%b want %b", cur.name, {e_r13, e_r23}, cur.f3);
          end
        end
      end
    end
  end

  initial begin
    #12 rst = 1'b0;
    step(IDLE, 1'b0, 1'b0, mk("reset_idle", 0, 0, 0, 0, 0, 0, 5'b00000, 0, 2'b00));

    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        step(ACTIVE_WRITE, 1'b0, 1'b0, mk("load_hold", 0, BR[5], 0, 0, 0, 0, 5'b00000, 0, 2'b00));
      end
      step(ACTIVE_WRITE, 1'b1, 1'b1, mk($sformatf("load%0d", i), 0, BR[i], 1, 0, 0, 0,
                                        (i == 15) ? 5'b10000 : 5'b00000, 0, 2'b00));
    end
    step(ACTIVE_WRITE, 1'b1, 1'b1, mk("load_wrap", 0, BR[0], 1, 0, 0, 0, 5'b00000, 0, 2'b00));
    step(IDLE, 1'b0, 1'b0, mk("idle_a", 0, 0, 0, 0, 0, 0, 5'b00000, 0, 2'b00));

    for (int i = 0; i < 3; i++) begin
      step(READ_1, 1'b0, 1'b0, mk($sformatf("rdlat_r1_%0d", i), 0, 0, 0, 0, 1, 0, 5'b01000, 1,
                                   (i == 2) ? 2'b10 : 2'b00));
    end
    for (int i = 0; i < 3; i++) begin
      step(READ_2, 1'b0, 1'b0, mk($sformatf("rdlat_r2_%0d", i), 1, 0, 0, 0, 1, 0, 5'b00100, 1,
                                   (i == 2) ? 2'b01 : 2'b00));
    end
    step(IDLE, 1'b0, 1'b0, mk("idle_b", 0, 0, 0, 0, 0, 0, 5'b00000, 0, 2'b00));

    run_bfly(32);
    step(DONE, 1'b0, 1'b0, mk("done", 0, 0, 0, 0, 0, 0, 5'b00000, 0, 2'b00));
    step(IDLE, 1'b0, 1'b0, mk("idle_c", 0, 0, 0, 0, 0, 0, 5'b00000, 0, 2'b00));

    for (int i = 0; i < 3; i++) begin
      step(ACTIVE_WRITE, 1'b1, 1'b1, mk($sformatf("reload%0d", i), 0, BR[i], 1, 0, 0, 0, 5'b00000, 0, 2'b00));
    end
    run_bfly(10);

    @(posedge clk);
    #1;
    stim_v = 1'b0;
    st     = READ_1;
    en     = 1'b0;
    wr     = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    step(READ_1, 1'b0, 1'b0, mk("post_rst_r1", 0, 0, 0, 0, 1, 0, 5'b01000, 0, 2'b00));
    step(READ_2, 1'b0, 1'b0, mk("post_rst_r2", 1, 0, 0, 0, 1, 0, 5'b00100, 0, 2'b00));
    step(ACTIVE_WRITE, 1'b1, 1'b1, mk("post_rst_load0", 0, BR[0], 1, 0, 0, 0, 5'b00000, 0, 2'b00));
    step(ACTIVE_WRITE, 1'b1, 1'b1, mk("post_rst_load1", 0, BR[1], 1, 0, 0, 0, 5'b00000, 0, 2'b00));

    @(posedge clk);
    #1;
    stim_v = 1'b0;
    st     = IDLE;
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected records left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
